// File: rtl/cointoss_sched.sv
// cointoss_sched: round-robin scheduler that shares one cointoss generator
// among NREQ requesters and runs a best-of-BEST_OF match per grant.
// Optional statistics counters (match_cnt, win_cnt) are built only when
// COINTOSS_SCHED_STATS_EN is defined.
module cointoss_sched #(
  parameter  int NREQ     = 4,
  parameter  int BEST_OF  = 3,
  parameter  int TOSS_LAT = 1,
  localparam int NEED     = (BEST_OF + 1) / 2,
  localparam int SW       = $clog2(NEED + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] call,
  input  logic [2:0]      toss_val,
  output logic [NREQ-1:0] gnt,
  output logic            toss_oe,
  output logic            busy,
  output logic            done,
  output logic            win,
  output logic [SW-1:0]   req_score,
  output logic [SW-1:0]   gen_score
`ifdef COINTOSS_SCHED_STATS_EN
  , output logic [15:0]   match_cnt
  , output logic [15:0]   win_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TOSS_LAT > 1) ? $clog2(TOSS_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TOSS_LAT - 1);
  localparam logic [SW-1:0] NEED_W   = SW'(NEED);

  typedef enum logic [2:0] {IDLE, GRANT, TOSS, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            call_q, call_d;
  logic [SW-1:0]   req_score_q, req_score_d;
  logic [SW-1:0]   gen_score_q, gen_score_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            toss_oe_q, toss_oe_d;
  logic            done_q, done_d;
  logic            win_q, win_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  // Only the result bit of the generator output matters.
  logic unused_toss_bits;
  assign unused_toss_bits = ^toss_val[2:1];

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_found && req[IW'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  // Next-state and registered-output logic of the match FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    call_d      = call_q;
    req_score_d = req_score_q;
    gen_score_d = gen_score_q;
    wait_cnt_d  = wait_cnt_q;
    toss_oe_d   = 1'b0;
    done_d      = 1'b0;
    win_d       = win_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          // Grant is registered on entry so it is visible in the GRANT cycle.
          state_d     = GRANT;
          gnt_d       = NREQ'(1) << pick_idx;
          gidx_d      = pick_idx;
          req_score_d = '0;
          gen_score_d = '0;
        end
      end
      GRANT: begin
        call_d    = call[gidx_q];
        state_d   = TOSS;
        toss_oe_d = 1'b1;
      end
      TOSS: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt_q == LAST_CNT) begin
          if (toss_val[0] == call_q) req_score_d = req_score_q + 1'b1;
          else                       gen_score_d = gen_score_q + 1'b1;
          if (req_score_d == NEED_W || gen_score_d == NEED_W) begin
            state_d = DONE;
            done_d  = 1'b1;
            win_d   = (req_score_d == NEED_W);
          end else begin
            state_d   = TOSS;
            toss_oe_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        win_d   = 1'b0;
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      call_q      <= 1'b0;
      req_score_q <= '0;
      gen_score_q <= '0;
      wait_cnt_q  <= '0;
      toss_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      call_q      <= call_d;
      req_score_q <= req_score_d;
      gen_score_q <= gen_score_d;
      wait_cnt_q  <= wait_cnt_d;
      toss_oe_q   <= toss_oe_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  assign gnt       = gnt_q;
  assign toss_oe   = toss_oe_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign win       = win_q;
  assign req_score = req_score_q;
  assign gen_score = gen_score_q;

`ifdef COINTOSS_SCHED_STATS_EN
  logic [15:0] match_cnt_q, match_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;

  // Saturating counters of decided matches and of matches won.
  always_comb begin
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    if (done_q && match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
    if (done_q && win_q && win_cnt_q != 16'hFFFF) win_cnt_d = win_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign win_cnt   = win_cnt_q;
`endif

endmodule
